// File: rtl/reg_regfile_resp_if.sv
// Register-bus link between an initiator and reg_regfile_resp.
// The initiator raises req.valid and holds the request fields stable until rsp.ready; the responder raises rsp.ready for exactly one cycle.
interface reg_regfile_resp_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   write;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   valid;
  } req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } rsp_t;

  req_t req;
  rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/reg_regfile_resp.sv
// Register-bank responder: NumRegs words with byte strobes, fixed access latency,
// decode error signalling and a concurrent hardware write port.
module reg_regfile_resp #(
  parameter int unsigned                   NumRegs    = 16,
  parameter int unsigned                   DataWidth  = 32,
  parameter int unsigned                   AddrWidth  = 32,
  parameter logic [AddrWidth-1:0]          BaseAddr   = '0,
  parameter int unsigned                   WaitCycles = 1,
  parameter logic [NumRegs*DataWidth-1:0]  ResetVal   = '0,
  localparam int unsigned                  IdxW       = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  reg_regfile_resp_if.slave            bus,
  output logic [NumRegs*DataWidth-1:0] regs_o,
  output logic [NumRegs-1:0]           wr_pulse_o,
  input  logic                         hw_we_i,
  input  logic [IdxW-1:0]              hw_idx_i,
  input  logic [DataWidth-1:0]         hw_wdata_i,
  output logic [1:0]                   dbg_state_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned CntW     = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  localparam logic [AddrWidth-1:0] AlignMask = (AddrWidth'(1) << OffW) - AddrWidth'(1);

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Wait    = 2'd1,
    Respond = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   capture;
  logic [CntW-1:0]        cnt_q;
  logic [AddrWidth-1:0]   cap_addr;
  logic                   cap_write;
  logic [DataWidth-1:0]   cap_wdata;
  logic [NumBytes-1:0]    cap_wstrb;
  logic [DataWidth-1:0]   regs_q [NumRegs];
  logic [DataWidth-1:0]   regs_d [NumRegs];

  logic [AddrWidth-1:0]   off;
  logic [AddrWidth-1:0]   idx_full;
  logic [IdxW-1:0]        idx;
  logic                   dec_err;
  logic                   respond;
  logic                   bus_we;

  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      Idle: begin
        if (bus.req.valid) begin
          capture = 1'b1;
          state_d = (WaitCycles > 0) ? Wait : Respond;
        end
      end
      Wait: begin
        if (cnt_q == CntW'(1)) state_d = Respond;
      end
      Respond: state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      cnt_q     <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cnt_q     <= CntW'(WaitCycles);
        cap_addr  <= bus.req.addr;
        cap_write <= bus.req.write;
        cap_wdata <= bus.req.wdata;
        cap_wstrb <= bus.req.wstrb;
      end else if (state_q == Wait) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  // Decode works only on the captured request, so a dropped valid cannot disturb it.
  assign off      = cap_addr - BaseAddr;
  assign idx_full = off >> OffW;
  assign idx      = idx_full[IdxW-1:0];
  assign dec_err  = (cap_addr < BaseAddr) ||
                    (idx_full >= AddrWidth'(NumRegs)) ||
                    ((cap_addr & AlignMask) != '0);
  assign respond  = (state_q == Respond);
  assign bus_we   = respond && cap_write && !dec_err;

  always_comb begin
    bus.rsp = '0;
    if (respond) begin
      bus.rsp.ready = 1'b1;
      bus.rsp.error = dec_err;
      if (!dec_err) bus.rsp.rdata = regs_q[idx];
    end
  end

  always_comb begin
    wr_pulse_o = '0;
    if (bus_we) wr_pulse_o[idx] = 1'b1;
  end

  // Hardware write lands first; bus-strobed bytes then override it on a collision.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
      if (hw_we_i && (hw_idx_i == IdxW'(i))) regs_d[i] = hw_wdata_i;
      if (bus_we && (idx == IdxW'(i))) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (cap_wstrb[b]) regs_d[i][b*8 +: 8] = cap_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= ResetVal[i*DataWidth +: DataWidth];
    end else begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar g = 0; g < NumRegs; g++) begin : g_flat
    assign regs_o[g*DataWidth +: DataWidth] = regs_q[g];
  end

endmodule

// File: doc/reg_regfile_resp.md
Name: reg_regfile_resp

Overview:
- Register-interface responder terminating a reg_intf bus, e.g. downstream of a register cut.
- Implements a bank of NumRegs word-wide registers with byte strobes, configurable access latency and error signalling.
- Registers are exposed to hardware as a flat vector. A hardware-side write port lets status logic update registers concurrently with bus traffic.

Parameters:
- NumRegs, 16, number of DataWidth-bit registers (>=1).
- DataWidth, 32, register and bus data width (multiple of 8).
- AddrWidth, 32, bus address width.
- BaseAddr, 0, byte address of register 0 (word aligned).
- WaitCycles, 1, extra idle cycles inserted before ready (>=0).
- ResetVal, '0, NumRegs*DataWidth reset image (register i at bits [i*DataWidth +: DataWidth]).
- req_t, logic, reg_intf request struct (addr, write, wdata, wstrb, valid).
- rsp_t, logic, reg_intf response struct (rdata, error, ready).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- req_i  in  req_t  bus request from initiator.
- rsp_o  out  rsp_t  bus response to initiator.
- regs_o  out  NumRegs*DataWidth  current register contents.
- wr_pulse_o  out  NumRegs  one-hot pulse, high in the cycle a bus write to register i commits.
- hw_we_i  in  1  hardware write enable.
- hw_idx_i  in  $clog2(NumRegs) (min 1)  hardware write register index.
- hw_wdata_i  in  DataWidth  hardware write data (full word).

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high.
- Reset values: state=Idle; rsp_o.ready=0; rsp_o.error=0; rsp_o.rdata=0; wr_pulse_o=0; regs_o=ResetVal.
- FSM states are Idle, Wait and Respond.
- Idle:
  - rsp_o.ready=0.
  - On req_i.valid, capture addr/write/wdata/wstrb into internal registers.
  - Load the counter with WaitCycles. Go to Wait if WaitCycles>0, else Respond.
- Wait:
  - Decrement the counter each cycle. Go to Respond when the counter reaches 1 (i.e. after WaitCycles cycles).
  - req_i is ignored.
- Respond:
  - rsp_o.ready=1 for exactly one cycle, then return to Idle.
  - Error, rdata and the write decision use the captured request only.
- Latency: ready rises WaitCycles+1 cycles after the first cycle valid is seen high.
  - Back-to-back requests: the next request is sampled in the Idle cycle after Respond, so minimum spacing is WaitCycles+2 cycles.
- Protocol:
  - The initiator holds valid and request fields stable until ready.
  - If valid drops early, the transaction still completes with the captured fields.
- Decode:
  - off = addr - BaseAddr (AddrWidth bits).
  - idx = off >> $clog2(DataWidth/8).
- error=1 in Respond when any of the following holds:
  - addr < BaseAddr;
  - idx >= NumRegs;
  - addr low $clog2(DataWidth/8) bits are non-zero.
- On error:
  - No register changes and wr_pulse_o stays 0.
  - rdata=0 for both reads and writes.
- Read: rdata = register[idx] value in the Respond cycle, including any hw write committed at earlier edges.
- Write:
  - In Respond, bytes of register[idx] with wstrb[b]=1 take wdata byte b at the closing clock edge.
  - wr_pulse_o[idx]=1 in the same cycle as ready, even when wstrb=0.
  - rdata on a write returns the pre-write register value.
- Hardware write:
  - When hw_we_i=1 and hw_idx_i<NumRegs, register[hw_idx_i] takes hw_wdata_i at the clock edge.
  - hw_idx_i>=NumRegs is ignored.
- Simultaneous bus and hardware write to the same register at the same edge:
  - Bus-strobed bytes take the bus data.
  - Non-strobed bytes take hw_wdata_i.
  - Writes to different registers both commit.
- Reset mid-transaction (including Wait or Respond):
  - Abort immediately: ready=0, registers=ResetVal, FSM=Idle.
  - No write commits.
- regs_o is driven directly from the register flops, with no extra latency.

Test Plan:
- Reset, then read each register (WaitCycles=1, BaseAddr=0x100):
  - Read of 0x104 gives ready in cycle 2 after valid, with rdata = ResetVal word 1 and error=0.
- Write then read back:
  - Write 0x108 with wdata=0xDEADBEEF and wstrb=0b0101 over register value 0x11223344.
  - Next read returns 0x11AD33EF.
  - wr_pulse_o[2]=1 in the ready cycle only.
- Error cases, each giving error=1, rdata=0, no register change and wr_pulse_o=0:
  - Write 0x0FC (below base).
  - Write 0x140 (idx=16).
  - Write 0x102 (misaligned).
- Collision: bus write to register 3 with wstrb=0b0011 and wdata=0xAAAAAAAA, plus hw_we_i=1, hw_idx_i=3, hw_wdata_i=0x55555555 at the same edge:
  - Register 3 becomes 0x5555AAAA.
- Latency sweep:
  - WaitCycles=0 gives ready exactly 1 cycle after valid.
  - WaitCycles=3 gives ready 4 cycles after valid.
  - Back-to-back reads are spaced 2 and 5 cycles respectively.
- Assert rst_i during the Wait state of a write of 0xFFFFFFFF to register 0:
  - ready is never asserted.
  - Register 0 equals ResetVal word 0.
  - A following read completes normally.
